// File: rtl/alu_pkg.sv
// Shared types for the decode/issue stage: ALU control codes, RV32I major
// opcodes and the ID/EX payload carried to the EX stage.
package alu_pkg;

  localparam int XLEN_P      = 32;
  localparam int RF_ADDR_W_P = 5;

  typedef enum logic [3:0] {
    ALU_ADD   = 4'b0000,
    ALU_SLL   = 4'b0001,
    ALU_SLT   = 4'b0010,
    ALU_SLTU  = 4'b0011,
    ALU_XOR   = 4'b0100,
    ALU_SRL   = 4'b0101,
    ALU_OR    = 4'b0110,
    ALU_AND   = 4'b0111,
    ALU_SUB   = 4'b1000,
    ALU_PASS2 = 4'b1001,
    ALU_SRA   = 4'b1101
  } alu_op_e;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;

  typedef struct packed {
    alu_op_e                  alu_ctrl;
    logic [XLEN_P-1:0]        src1;
    logic [XLEN_P-1:0]        src2;
    logic [XLEN_P-1:0]        store_data;
    logic [RF_ADDR_W_P-1:0]   rd;
    logic                     reg_we;
    logic                     mem_rd;
    logic                     mem_wr;
    logic                     illegal;
  } id_ex_t;

  function automatic logic [XLEN_P-1:0] sext12(input logic [11:0] imm);
    return {{(XLEN_P-12){imm[11]}}, imm};
  endfunction

endpackage

// File: rtl/id_dec.sv
// Combinational RV32I decoder: turns an instruction plus its operand values
// into the ID/EX payload and reports which source registers it reads.
module id_dec
  import alu_pkg::*;
(
  input  logic [XLEN_P-1:0] instr,
  input  logic [XLEN_P-1:0] pc,
  input  logic [XLEN_P-1:0] rs1_val,
  input  logic [XLEN_P-1:0] rs2_val,
  output id_ex_t            dec,
  output logic              rs1_used,
  output logic              rs2_used
);

  logic [6:0]          opcode;
  logic [2:0]          funct3;
  logic [6:0]          funct7;
  logic [XLEN_P-1:0]   imm_i;
  logic [XLEN_P-1:0]   imm_s;
  logic [XLEN_P-1:0]   imm_u;
  logic [XLEN_P-1:0]   shamt;

  assign opcode = instr[6:0];
  assign funct3 = instr[14:12];
  assign funct7 = instr[31:25];
  assign imm_i  = sext12(instr[31:20]);
  assign imm_s  = sext12({instr[31:25], instr[11:7]});
  assign imm_u  = {instr[31:12], 12'h000};
  assign shamt  = {{(XLEN_P-5){1'b0}}, instr[24:20]};

  always_comb begin
    dec            = '0;
    dec.alu_ctrl   = ALU_ADD;
    dec.src1       = rs1_val;
    dec.src2       = rs2_val;
    dec.store_data = rs2_val;
    dec.rd         = instr[11:7];
    rs1_used       = 1'b0;
    rs2_used       = 1'b0;

    case (opcode)
      OP_R: begin
        dec.alu_ctrl = alu_op_e'({funct7[5], funct3});
        dec.reg_we   = 1'b1;
        rs1_used     = 1'b1;
        rs2_used     = 1'b1;
      end
      OP_IMM: begin
        dec.reg_we = 1'b1;
        rs1_used   = 1'b1;
        // Shifts carry only the shift amount; funct7 picks SRL vs SRA
        if (funct3 == 3'b001 || funct3 == 3'b101) begin
          dec.alu_ctrl = alu_op_e'({funct3[2] & funct7[5], funct3});
          dec.src2     = shamt;
          dec.illegal  = (funct7 != 7'b0000000) && (funct7 != 7'b0100000);
        end else begin
          dec.alu_ctrl = alu_op_e'({1'b0, funct3});
          dec.src2     = imm_i;
        end
      end
      OP_LOAD: begin
        dec.src2   = imm_i;
        dec.reg_we = 1'b1;
        dec.mem_rd = 1'b1;
        rs1_used   = 1'b1;
      end
      OP_STORE: begin
        dec.src2   = imm_s;
        dec.mem_wr = 1'b1;
        rs1_used   = 1'b1;
        rs2_used   = 1'b1;
      end
      OP_LUI: begin
        dec.alu_ctrl = ALU_PASS2;
        dec.src1     = '0;
        dec.src2     = imm_u;
        dec.reg_we   = 1'b1;
      end
      OP_AUIPC: begin
        dec.src1   = pc;
        dec.src2   = imm_u;
        dec.reg_we = 1'b1;
      end
      OP_JAL, OP_JALR: begin
        // Link value pc+4; JALR still reads rs1 for its target
        dec.src1   = pc;
        dec.src2   = 32'd4;
        dec.reg_we = 1'b1;
        rs1_used   = (opcode == OP_JALR);
      end
      OP_BRANCH: begin
        dec.alu_ctrl = ALU_SUB;
        rs1_used     = 1'b1;
        rs2_used     = 1'b1;
      end
      default: begin
        dec.illegal = 1'b1;
      end
    endcase

    if (dec.rd == '0) dec.reg_we = 1'b0;
  end

endmodule

// File: rtl/id_ex_issue.sv
// Decode/issue stage with ID/EX register, valid/ready flow control, load-use
// bubble and flush. Define ISSUE_WB_BYPASS_EN to forward writeback data.
module id_ex_issue
  import alu_pkg::*;
#(
  parameter int XLEN      = 32,
  parameter int RF_ADDR_W = 5
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [31:0]          instr,
  input  logic [XLEN-1:0]      pc,
  input  logic [XLEN-1:0]      rs1_data,
  input  logic [XLEN-1:0]      rs2_data,
  input  logic                 wb_we,
  input  logic [RF_ADDR_W-1:0] wb_rd,
  input  logic [XLEN-1:0]      wb_data,
  input  logic                 flush,
  input  logic                 ex_ready,
  output logic                 ex_valid,
  output logic [3:0]           ex_alu_ctrl,
  output logic [XLEN-1:0]      ex_src1,
  output logic [XLEN-1:0]      ex_src2,
  output logic [XLEN-1:0]      ex_store_data,
  output logic [RF_ADDR_W-1:0] ex_rd,
  output logic                 ex_reg_we,
  output logic                 ex_mem_rd,
  output logic                 ex_mem_wr,
  output logic                 ex_illegal
);

  logic [XLEN-1:0]      rs_raw [2];
  logic [XLEN-1:0]      rs_val [2];
  logic [RF_ADDR_W-1:0] rs_idx [2];

  assign rs_raw[0] = rs1_data;
  assign rs_raw[1] = rs2_data;
  assign rs_idx[0] = instr[19:15];
  assign rs_idx[1] = instr[24:20];

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_src
`ifdef ISSUE_WB_BYPASS_EN
      // Covers a register-file write landing in the same cycle as the read
      assign rs_val[gi] = (wb_we && (wb_rd != '0) && (wb_rd == rs_idx[gi]))
                          ? wb_data : rs_raw[gi];
`else
      assign rs_val[gi] = rs_raw[gi];
`endif
    end
  endgenerate

`ifndef ISSUE_WB_BYPASS_EN
  logic unused_wb;
  assign unused_wb = ^{wb_we, wb_rd, wb_data};
`endif

  id_ex_t dec;
  logic   rs1_used;
  logic   rs2_used;

  id_dec u_dec (
    .instr    (instr),
    .pc       (pc),
    .rs1_val  (rs_val[0]),
    .rs2_val  (rs_val[1]),
    .dec      (dec),
    .rs1_used (rs1_used),
    .rs2_used (rs2_used)
  );

  logic   ex_valid_reg;
  logic   ex_valid_next;
  id_ex_t ex_payload_reg;
  id_ex_t ex_payload_next;
  logic   advance;
  logic   hazard;
  logic   accept;

  assign advance = !ex_valid_reg || ex_ready;

  // A load in EX cannot feed a consumer in ID until it has left the pipe
  assign hazard = ex_valid_reg && ex_payload_reg.mem_rd && (ex_payload_reg.rd != '0) &&
                  ((rs1_used && (rs_idx[0] == ex_payload_reg.rd)) ||
                   (rs2_used && (rs_idx[1] == ex_payload_reg.rd)));

  assign in_ready = advance && !hazard && !flush;
  assign accept   = in_valid && in_ready;

  always_comb begin
    ex_valid_next   = ex_valid_reg;
    ex_payload_next = ex_payload_reg;
    if (flush) begin
      ex_valid_next = 1'b0;
    end else if (advance) begin
      ex_valid_next = accept;
      if (accept) ex_payload_next = dec;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ex_valid_reg   <= 1'b0;
      ex_payload_reg <= '0;
    end else begin
      ex_valid_reg   <= ex_valid_next;
      ex_payload_reg <= ex_payload_next;
    end
  end

  assign ex_valid      = ex_valid_reg;
  assign ex_alu_ctrl   = ex_payload_reg.alu_ctrl;
  assign ex_src1       = ex_payload_reg.src1;
  assign ex_src2       = ex_payload_reg.src2;
  assign ex_store_data = ex_payload_reg.store_data;
  assign ex_rd         = ex_payload_reg.rd;
  assign ex_reg_we     = ex_payload_reg.reg_we;
  assign ex_mem_rd     = ex_payload_reg.mem_rd;
  assign ex_mem_wr     = ex_payload_reg.mem_wr;
  assign ex_illegal    = ex_payload_reg.illegal;

endmodule

// File: tb/tb_id_ex_issue.sv
// Self-checking bench for id_ex_issue: directed decode table, hand-written
// stall/flush/reset/bypass sequences, then random traffic against a model.
module tb_id_ex_issue;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] instr;
  logic [31:0] pc;
  logic [31:0] rs1_data;
  logic [31:0] rs2_data;
  logic        wb_we;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;
  logic        flush;
  logic        ex_ready;
  logic        ex_valid;
  logic [3:0]  ex_alu_ctrl;
  logic [31:0] ex_src1;
  logic [31:0] ex_src2;
  logic [31:0] ex_store_data;
  logic [4:0]  ex_rd;
  logic        ex_reg_we;
  logic        ex_mem_rd;
  logic        ex_mem_wr;
  logic        ex_illegal;

  id_ex_issue dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .instr(instr), .pc(pc), .rs1_data(rs1_data), .rs2_data(rs2_data),
    .wb_we(wb_we), .wb_rd(wb_rd), .wb_data(wb_data), .flush(flush),
    .ex_ready(ex_ready), .ex_valid(ex_valid), .ex_alu_ctrl(ex_alu_ctrl),
    .ex_src1(ex_src1), .ex_src2(ex_src2), .ex_store_data(ex_store_data),
    .ex_rd(ex_rd), .ex_reg_we(ex_reg_we), .ex_mem_rd(ex_mem_rd),
    .ex_mem_wr(ex_mem_wr), .ex_illegal(ex_illegal)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic [31:0] ins, p, a, b;
    logic [3:0]  ctrl;
    logic [31:0] s1, s2;
    logic [4:0]  rd;
    logic        we, mrd, mwr, ill;
  } vec_t;

  typedef struct packed {
    logic [3:0]  ctrl;
    logic [31:0] s1, s2, sd;
    logic [4:0]  rd;
    logic        we, mrd, mwr, ill;
    logic        use1, use2;
  } exp_t;

  function automatic logic [108:0] pack(input exp_t e);
    return {e.ctrl, e.s1, e.s2, e.sd, e.rd, e.we, e.mrd, e.mwr, e.ill};
  endfunction

  function automatic logic [108:0] dut_pack();
    return {ex_alu_ctrl, ex_src1, ex_src2, ex_store_data, ex_rd,
            ex_reg_we, ex_mem_rd, ex_mem_wr, ex_illegal};
  endfunction

  // Reference decode written straight from the instruction-set rules
  function automatic exp_t ref_decode(input logic [31:0] ins, input logic [31:0] p,
                                      input logic [31:0] a, input logic [31:0] b);
    exp_t e;
    logic [2:0]  f3 = ins[14:12];
    logic [6:0]  f7 = ins[31:25];
    logic [31:0] ii = {{20{ins[31]}}, ins[31:20]};
    logic [31:0] is = {{20{ins[31]}}, ins[31:25], ins[11:7]};
    logic [31:0] iu = {ins[31:12], 12'h000};
    e = '0;
    e.s1 = a; e.s2 = b; e.sd = b; e.rd = ins[11:7];
    case (ins[6:0])
      7'h33: begin e.ctrl = {f7[5], f3}; e.we = 1; e.use1 = 1; e.use2 = 1; end
      7'h13: begin
        e.we = 1; e.use1 = 1;
        if (f3 == 3'd1 || f3 == 3'd5) begin
          e.ctrl = (f3 == 3'd5) ? {f7[5], f3} : {1'b0, f3};
          e.s2   = 32'(ins[24:20]);
          e.ill  = !(f7 == 7'h00 || f7 == 7'h20);
        end else begin
          e.ctrl = {1'b0, f3};
          e.s2   = ii;
        end
      end
      7'h03: begin e.s2 = ii; e.we = 1; e.mrd = 1; e.use1 = 1; end
      7'h23: begin e.s2 = is; e.mwr = 1; e.use1 = 1; e.use2 = 1; end
      7'h37: begin e.ctrl = 4'b1001; e.s1 = 0; e.s2 = iu; e.we = 1; end
      7'h17: begin e.s1 = p; e.s2 = iu; e.we = 1; end
      7'h6f: begin e.s1 = p; e.s2 = 4; e.we = 1; end
      7'h67: begin e.s1 = p; e.s2 = 4; e.we = 1; e.use1 = 1; end
      7'h63: begin e.ctrl = 4'b1000; e.use1 = 1; e.use2 = 1; end
      default: e.ill = 1;
    endcase
    if (e.rd == 0) e.we = 0;
    return e;
  endfunction

  function automatic logic [31:0] byp(input logic [4:0] idx, input logic [31:0] raw);
    logic en;
`ifdef ISSUE_WB_BYPASS_EN
    en = 1'b1;
`else
    en = 1'b0;
`endif
    return (en && wb_we && wb_rd != 0 && wb_rd == idx) ? wb_data : raw;
  endfunction

  task automatic apply(input logic [31:0] ins, input logic [31:0] p,
                       input logic [31:0] a, input logic [31:0] b);
    in_valid = 1'b1; instr = ins; pc = p; rs1_data = a; rs2_data = b;
  endtask

  vec_t        tbl[12];
  logic [6:0]  ops[11];
  exp_t        m_p, d;
  logic        m_valid, exp_rdy, hz;
  logic [31:0] exp_byp;

  initial begin
    rst = 1'b1; in_valid = 0; instr = 0; pc = 0; rs1_data = 0; rs2_data = 0;
    wb_we = 0; wb_rd = 0; wb_data = 0; flush = 0; ex_ready = 1;

    tbl[0]  = '{32'h002081B3, 32'h0,   32'd5,         32'd7,  4'h0, 32'd5,         32'd7,         5'd3, 1, 0, 0, 0};
    tbl[1]  = '{32'h4030D213, 32'h0,   32'hF000_0000, 32'd0,  4'hD, 32'hF000_0000, 32'd3,         5'd4, 1, 0, 0, 0};
    tbl[2]  = '{32'h123452B7, 32'h0,   32'd1,         32'd2,  4'h9, 32'd0,         32'h1234_5000, 5'd5, 1, 0, 0, 0};
    tbl[3]  = '{32'h40208433, 32'h0,   32'd20,        32'd3,  4'h8, 32'd20,        32'd3,         5'd8, 1, 0, 0, 0};
    tbl[4]  = '{32'h00001497, 32'h100, 32'd1,         32'd2,  4'h0, 32'h100,       32'h1000,      5'd9, 1, 0, 0, 0};
    tbl[5]  = '{32'h000000EF, 32'h200, 32'd1,         32'd2,  4'h0, 32'h200,       32'd4,         5'd1, 1, 0, 0, 0};
    tbl[6]  = '{32'h0020A423, 32'h0,   32'h40,        32'h55, 4'h0, 32'h40,        32'd8,         5'd8, 0, 0, 1, 0};
    tbl[7]  = '{32'h0000007F, 32'h0,   32'd1,         32'd2,  4'h0, 32'd1,         32'd2,         5'd0, 0, 0, 0, 1};
    tbl[8]  = '{32'hFFF08013, 32'h0,   32'd10,        32'd0,  4'h0, 32'd10,        32'hFFFF_FFFF, 5'd0, 0, 0, 0, 0};
    tbl[9]  = '{32'h02309213, 32'h0,   32'd6,         32'd0,  4'h1, 32'd6,         32'd3,         5'd4, 1, 0, 0, 1};
    tbl[10] = '{32'h00208063, 32'h0,   32'd9,         32'd9,  4'h8, 32'd9,         32'd9,         5'd0, 0, 0, 0, 0};
    tbl[11] = '{32'h0000A303, 32'h0,   32'h80,        32'd0,  4'h0, 32'h80,        32'd0,         5'd6, 1, 1, 0, 0};

    ops = '{7'h33, 7'h13, 7'h03, 7'h23, 7'h37, 7'h17, 7'h6f, 7'h67, 7'h63, 7'h7f, 7'h0b};

    repeat (2) @(posedge clk);
    #1;
    check("reset_outputs", {ex_valid, dut_pack()}, '0);
    check("reset_in_ready", in_ready, 1'b1);
    rst = 1'b0;

    // Directed decode table, one accepted instruction per cycle
    for (int i = 0; i < 12; i++) begin
      apply(tbl[i].ins, tbl[i].p, tbl[i].a, tbl[i].b);
      tick();
      $display("vec %0d instr=%h ctrl=%b src1=%h src2=%h rd=%0d", i, tbl[i].ins,
               ex_alu_ctrl, ex_src1, ex_src2, ex_rd);
      check("tbl_valid", ex_valid, 1'b1);
      check($sformatf("tbl_%0d", i),
            {ex_alu_ctrl, ex_src1, ex_src2, ex_rd, ex_reg_we, ex_mem_rd, ex_mem_wr, ex_illegal},
            {tbl[i].ctrl, tbl[i].s1, tbl[i].s2, tbl[i].rd, tbl[i].we, tbl[i].mrd, tbl[i].mwr, tbl[i].ill});
    end

    // Load-use: LW x6 is in EX, ADD x7,x6,x2 waits one bubble
    apply(32'h002303B3, 32'h0, 32'h33, 32'h44);
    #1 check("lu_in_ready_low", in_ready, 1'b0);
    tick();
    $display("seq load-use bubble ex_valid=%b", ex_valid);
    check("lu_bubble", ex_valid, 1'b0);
    check("lu_in_ready_high", in_ready, 1'b1);
    tick();
    $display("seq load-use issue ctrl=%b src1=%h rd=%0d", ex_alu_ctrl, ex_src1, ex_rd);
    check("lu_issue", {ex_valid, ex_alu_ctrl, ex_src1, ex_src2, ex_rd},
          {1'b1, 4'h0, 32'h33, 32'h44, 5'd7});

    // EX stall for three cycles, then release
    ex_ready = 1'b0;
    apply(32'h40208433, 32'h0, 32'd9, 32'd4);
    for (int i = 0; i < 3; i++) begin
      #1 check("stall_in_ready", in_ready, 1'b0);
      tick();
      $display("seq stall %0d ex_valid=%b src1=%h", i, ex_valid, ex_src1);
      check("stall_hold", {ex_valid, ex_alu_ctrl, ex_src1, ex_src2, ex_rd},
            {1'b1, 4'h0, 32'h33, 32'h44, 5'd7});
    end
    ex_ready = 1'b1;
    #1 check("release_in_ready", in_ready, 1'b1);
    tick();
    $display("seq release ctrl=%b src1=%h rd=%0d", ex_alu_ctrl, ex_src1, ex_rd);
    check("release_issue", {ex_valid, ex_alu_ctrl, ex_src1, ex_src2, ex_rd},
          {1'b1, 4'h8, 32'd9, 32'd4, 5'd8});

    // Flush while SUB held and EX stalled
    ex_ready = 1'b0; flush = 1'b1;
    apply(32'h002081B3, 32'h0, 32'd1, 32'd2);
    #1 check("flush_in_ready", in_ready, 1'b0);
    tick();
    $display("seq flush ex_valid=%b", ex_valid);
    check("flush_valid", ex_valid, 1'b0);
    flush = 1'b0; ex_ready = 1'b1;

    // Asynchronous reset in the middle of a stall
    tick();
    check("pre_rst_valid", ex_valid, 1'b1);
    ex_ready = 1'b0;
    tick();
    #2 rst = 1'b1;
    #1;
    $display("seq async reset ex_valid=%b", ex_valid);
    check("async_rst", {ex_valid, dut_pack()}, '0);
    tick();
    rst = 1'b0; ex_ready = 1'b1;

    // Same-cycle writeback to rs1
    wb_we = 1'b1; wb_rd = 5'd1; wb_data = 32'hAA;
    apply(32'h00008133, 32'h0, 32'h11, 32'h0);
`ifdef ISSUE_WB_BYPASS_EN
    exp_byp = 32'hAA;
`else
    exp_byp = 32'h11;
`endif
    tick();
    $display("seq bypass src1=%h", ex_src1);
    check("bypass_src1", {ex_valid, ex_src1}, {1'b1, exp_byp});
    wb_we = 1'b0;

    // Random traffic against the reference model
    in_valid = 1'b0;
    tick();
    m_valid = 1'b0;
    m_p = '0;
    check("rnd_start_valid", ex_valid, 1'b0);
    for (int c = 0; c < 1500; c++) begin
      instr = $urandom;
      instr[6:0]   = ops[$urandom_range(0, 10)];
      instr[11:7]  = 5'($urandom_range(0, 3));
      instr[19:15] = 5'($urandom_range(0, 3));
      instr[24:20] = 5'($urandom_range(0, 3));
      if ($urandom_range(0, 3) != 0) instr[31:25] = $urandom_range(0, 1) ? 7'h20 : 7'h00;
      pc       = $urandom & 32'hFFFF_FFFC;
      rs1_data = $urandom;
      rs2_data = $urandom;
      in_valid = ($urandom_range(0, 3) != 0);
      ex_ready = ($urandom_range(0, 3) != 0);
      flush    = ($urandom_range(0, 15) == 0);
      wb_we    = $urandom_range(0, 1);
      wb_rd    = 5'($urandom_range(0, 3));
      wb_data  = $urandom;

      d = ref_decode(instr, pc, byp(instr[19:15], rs1_data), byp(instr[24:20], rs2_data));
      hz = m_valid && m_p.mrd && m_p.rd != 0 &&
           ((d.use1 && instr[19:15] == m_p.rd) || (d.use2 && instr[24:20] == m_p.rd));
      exp_rdy = (!m_valid || ex_ready) && !hz && !flush;
      #1 check("rnd_in_ready", in_ready, exp_rdy);

      if (flush) m_valid = 1'b0;
      else if (!m_valid || ex_ready) begin
        m_valid = in_valid && exp_rdy;
        if (m_valid) m_p = d;
      end
      tick();
      if (in_valid && exp_rdy)
        $display("rnd %0d accept instr=%h ctrl=%b rd=%0d", c, instr, ex_alu_ctrl, ex_rd);
      check("rnd_valid", ex_valid, m_valid);
      if (m_valid) check("rnd_payload", dut_pack(), pack(m_p));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/id_ex_issue.md
Name: id_ex_issue

Overview:
- Decode/issue stage feeding the EX-stage ALU.
- Accepts a fetched RV32I instruction plus register-file read data and decodes it into the ALU's 4-bit control code and two operands.
- Holds the decoded result in an ID/EX pipeline register with valid/ready flow control, a load-use bubble and synchronous flush.
- Sits between the instruction fetch/register file and the ALU/EX stage.

Parameters:
- XLEN, 32, datapath width
- RF_ADDR_W, 5, register index width

Ports:
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  asynchronous, active-high reset
- in_valid  in  1  instruction/operands valid
- in_ready  out  1  stage accepts this cycle
- instr  in  32  RV32I instruction word
- pc  in  XLEN  instruction address
- rs1_data  in  XLEN  register-file read, rs1
- rs2_data  in  XLEN  register-file read, rs2
- wb_we  in  1  writeback write enable (bypass source)
- wb_rd  in  RF_ADDR_W  writeback destination
- wb_data  in  XLEN  writeback data
- flush  in  1  kill held and incoming instruction
- ex_ready  in  1  EX consumes ex_* this cycle
- ex_valid  out  1  ex_* hold a live instruction
- ex_alu_ctrl  out  4  ALU control code
- ex_src1  out  XLEN  ALU operand 1
- ex_src2  out  XLEN  ALU operand 2
- ex_store_data  out  XLEN  rs2 value for stores
- ex_rd  out  RF_ADDR_W  destination register
- ex_reg_we  out  1  writes rd
- ex_mem_rd  out  1  load
- ex_mem_wr  out  1  store
- ex_illegal  out  1  unrecognised opcode/funct

Behaviour:
- Reset: all ex_* outputs are 0. in_ready follows its combinational equation.
- ALU codes:
  - ADD 0000, SUB 1000, SLL 0001, SLT 0010, SLTU 0011
  - XOR 0100, SRL 0101, SRA 1101, OR 0110, AND 0111, PASS2 (LUI) 1001
- Decode, R-type (0110011): code = {funct7[5], funct3}; src1 = rs1, src2 = rs2.
- Decode, I-type ALU (0010011):
  - code = {funct3==101 ? funct7[5] : 0, funct3}; src2 = sign-extended imm.
  - SLLI/SRLI/SRAI with funct7 other than 0000000/0100000 raise illegal.
- Decode, load (0000011) and store (0100011): ADD, src1 = rs1, src2 = imm_i or imm_s.
- Decode, LUI: PASS2, src2 = imm_u.
- Decode, AUIPC: ADD, src1 = pc, src2 = imm_u.
- Decode, JAL/JALR: ADD, src1 = pc, src2 = 4, reg_we = 1.
- Decode, branch (1100011): SUB, src1 = rs1, src2 = rs2, reg_we = 0.
- Decode, any other opcode: ex_illegal = 1, reg_we = mem_rd = mem_wr = 0, code ADD.
- reg_we is forced 0 when rd == 0.
- Register update: advance = !ex_valid | ex_ready.
- Load-use hazard: hz = ex_valid & ex_mem_rd & ex_rd != 0 & (rs1 used & rs1 == ex_rd | rs2 used & rs2 == ex_rd).
- Handshake: in_ready = advance & !hz & !flush. Accept = in_valid & in_ready; on accept, the decoded value is registered at the next edge, giving 1-cycle latency.
- advance without accept: ex_valid ← 0 (bubble). All other ex_* fields hold and are don't-care while invalid.
- !advance: all ex_* hold stable (EX stall).
- flush: ex_valid ← 0 at the next edge regardless of ex_ready; the incoming instruction is not accepted. Flush dominates stall and hazard.
- Hazard with ex_ready = 1: one bubble is inserted; the same instruction is accepted the following cycle (the source must hold in_valid and instr).
- rst is asserted asynchronously mid-operation: ex_valid drops immediately; no partial state survives.

Optional Feature:
- Macro: ISSUE_WB_BYPASS_EN.
- Defined: when wb_we & wb_rd != 0 & wb_rd == rs1 (or rs2), wb_data replaces rs1_data (or rs2_data) before operand selection, covering same-cycle register-file write/read.
- Undefined: wb_* ports remain but are ignored; rs*_data are used directly.

Decomposition:
- Package alu_pkg:
  - 4-bit alu_op_e enum with the codes above
  - RV32I opcode localparams
  - id_ex_t struct bundling the ex_* payload
- Sub-module id_dec: purely combinational; instr, pc, rs1/rs2 values in, id_ex_t plus rs1/rs2 use flags out.
- id_ex_issue holds the hazard logic, bypass and pipeline register.

Test Plan:
- ADD x3,x1,x2 with rs1 = 5, rs2 = 7, ex_ready = 1 → next cycle ex_valid = 1, ex_alu_ctrl = 0000, src1 = 5, src2 = 7, ex_rd = 3, ex_reg_we = 1.
- SRAI x4,x1,3 (0x4030D213), rs1 = 0xF000_0000 → ex_alu_ctrl = 1101, ex_src2 = 3. LUI x5,0x12345 → 1001, src2 = 0x1234_5000.
- LW x6,0(x1) then ADD x7,x6,x2 back-to-back → in_ready = 0 for one cycle, ex_valid = 0 bubble, ADD issued the cycle after.
- ex_ready = 0 for 3 cycles with ex_valid = 1 → ex_* unchanged, in_ready = 0. Release → next instruction accepted.
- flush asserted while holding SUB and in_valid = 1 → next cycle ex_valid = 0, input not accepted. Assert rst mid-stall → ex_valid = 0 immediately.
- ISSUE_WB_BYPASS_EN: wb_we = 1, wb_rd = 1, wb_data = 0xAA, rs1_data = 0x11, ADD x2,x1,x0 → ex_src1 = 0xAA. Without the macro → 0x11.
